// File: rtl/spi_slave_if.sv
// SPI responder: oversamples SCK/SS_n/MOSI in the clk_i domain and
// exchanges bytes with the fabric glue through valid/ready strobes.
module spi_slave_if #(
    parameter bit         CPOL        = 1'b0,
    parameter bit         CPHA        = 1'b0,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_TX     = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_sck_i,
    input  logic       spi_ss_n_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       frame_end_o,
    output logic       tx_underrun_o,
    output logic       busy_o
);

    localparam logic [1:0] ST_WAIT   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   prime;
    logic                   sck_d;
    logic                   ss_d;
    logic [1:0]             state;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [7:0]             tx_shift;
    logic [7:0]             hold_data;
    logic                   hold_full;
    logic                   pend_load;

    logic sck_s, ss_s, mosi_s, primed;
    logic sck_rise, sck_fall, lead_e, trail_e;
    logic sample_e, shift_e, ss_fall, ss_rise;
    logic enter, in_frame, do_sample, do_shift;
    logic do_load, accept, consume;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    // Stale reset values must drain from the chain before SS_n is trusted.
    assign primed = prime[SYNC_STAGES];

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign lead_e   = CPOL ? sck_fall : sck_rise;
    assign trail_e  = CPOL ? sck_rise : sck_fall;
    assign sample_e = CPHA ? trail_e : lead_e;
    assign shift_e  = CPHA ? lead_e : trail_e;
    assign ss_fall  = ~ss_s & ss_d;
    assign ss_rise  = ss_s & ~ss_d;

    assign enter     = (state == ST_IDLE) && ss_fall;
    assign in_frame  = (state == ST_ACTIVE) && !ss_rise;
    assign do_sample = in_frame && sample_e;
    assign do_shift  = in_frame && shift_e;
    assign do_load   = CPHA ? (do_shift && (bit_cnt == 3'd0))
                            : (enter || (do_shift && pend_load));
    assign accept    = tx_valid_i && !hold_full;
    assign consume   = do_load && hold_full;

    assign spi_miso_o    = tx_shift[7];
    assign spi_miso_oe_o = (state == ST_ACTIVE);
    assign busy_o        = (state == ST_ACTIVE);
    assign tx_ready_o    = !hold_full;

    // Input synchronisers plus one delay flop for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_sync  <= {SYNC_STAGES{CPOL}};
            ss_sync   <= '1;
            mosi_sync <= '0;
            sck_d     <= CPOL;
            ss_d      <= 1'b1;
            prime     <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
            sck_d     <= sck_s;
            ss_d      <= ss_s;
            prime     <= {prime[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Frame state: wait for SS_n high after reset, then track select.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_WAIT;
            frame_end_o <= 1'b0;
        end else begin
            frame_end_o <= 1'b0;
            case (state)
                ST_WAIT: if (primed && ss_s) state <= ST_IDLE;
                ST_IDLE: if (ss_fall) state <= ST_ACTIVE;
                ST_ACTIVE: begin
                    if (ss_rise) begin
                        state       <= ST_IDLE;
                        frame_end_o <= 1'b1;
                    end
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    // Receive shifter and bit counter; a byte completes on the 7->0 wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt    <= 3'd0;
            rx_shift   <= 7'd0;
            rx_data_o  <= 8'd0;
            rx_valid_o <= 1'b0;
            pend_load  <= 1'b0;
        end else begin
            rx_valid_o <= 1'b0;
            if (enter) begin
                bit_cnt   <= 3'd0;
                pend_load <= 1'b0;
            end else if (do_sample) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    rx_data_o  <= {rx_shift, mosi_s};
                    rx_valid_o <= 1'b1;
                    pend_load  <= 1'b1;
                end
            end else if (do_shift) begin
                pend_load <= 1'b0;
            end
        end
    end

    // Transmit shifter, holding register and underrun flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_shift      <= 8'hFF;
            hold_data     <= 8'd0;
            hold_full     <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            if (do_load) begin
                tx_shift <= hold_full ? hold_data : IDLE_TX;
            end else if (do_shift) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
            if (accept) begin
                hold_data <= tx_data_i;
                hold_full <= 1'b1;
            end else if (consume) begin
                hold_full <= 1'b0;
            end
            if (do_load && !hold_full) begin
                tx_underrun_o <= 1'b1;
            end else if (accept) begin
                tx_underrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a mode-0 and a mode-3 instance driven by a
// behavioural SPI master and checked against a byte-queue model.
module tb_spi_slave_if;

    localparam int HALF = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst, sck, ss_n, mosi, miso, oe;
    logic [1:0]      txv, txr, rxv, fe, uf, busy;
    logic [1:0][7:0] txd, rxd;

    int total = 0;
    int bad   = 0;

    int         rxv_cnt [2];
    int         fe_cnt  [2];
    logic [7:0] rx_last [2];

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    bit         ufm [2];

    spi_slave_if #(.CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2),
                   .IDLE_TX(8'hFF)) u_m0 (
        .clk_i(clk), .rst_i(rst[0]),
        .spi_sck_i(sck[0]), .spi_ss_n_i(ss_n[0]), .spi_mosi_i(mosi[0]),
        .spi_miso_o(miso[0]), .spi_miso_oe_o(oe[0]),
        .tx_data_i(txd[0]), .tx_valid_i(txv[0]), .tx_ready_o(txr[0]),
        .rx_data_o(rxd[0]), .rx_valid_o(rxv[0]), .frame_end_o(fe[0]),
        .tx_underrun_o(uf[0]), .busy_o(busy[0])
    );

    spi_slave_if #(.CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2),
                   .IDLE_TX(8'hFF)) u_m3 (
        .clk_i(clk), .rst_i(rst[1]),
        .spi_sck_i(sck[1]), .spi_ss_n_i(ss_n[1]), .spi_mosi_i(mosi[1]),
        .spi_miso_o(miso[1]), .spi_miso_oe_o(oe[1]),
        .tx_data_i(txd[1]), .tx_valid_i(txv[1]), .tx_ready_o(txr[1]),
        .rx_data_o(rxd[1]), .rx_valid_o(rxv[1]), .frame_end_o(fe[1]),
        .tx_underrun_o(uf[1]), .busy_o(busy[1])
    );

    // Pulse counters for rx_valid_o and frame_end_o.
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (rxv[m]) begin
                rxv_cnt[m] = rxv_cnt[m] + 1;
                rx_last[m] = rxd[m];
            end
            if (fe[m]) fe_cnt[m] = fe_cnt[m] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int m);
        return (m == 0) ? q0.size() : q1.size();
    endfunction

    function automatic void mpush(input int m, input logic [7:0] d);
        if (m == 0) q0.push_back(d);
        else        q1.push_back(d);
        ufm[m] = 1'b0;
    endfunction

    // Model of one shift-register load: next queued byte, else idle fill.
    function automatic logic [7:0] mload(input int m);
        logic [7:0] r;
        if (qsize(m) > 0) begin
            r = (m == 0) ? q0.pop_front() : q1.pop_front();
        end else begin
            r = 8'hFF;
            ufm[m] = 1'b1;
        end
        return r;
    endfunction

    task automatic push(input int m, input logic [7:0] d);
        int n;
        @(negedge clk);
        txd[m] = d;
        txv[m] = 1'b1;
        n = 0;
        while (!txr[m] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
        @(negedge clk);
        txv[m] = 1'b0;
    endtask

    task automatic ss_low(input int m);
        @(negedge clk);
        ss_n[m] = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic ss_high(input int m);
        repeat (HALF) @(negedge clk);
        ss_n[m] = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // Master side of nb bits, MSB first, in the instance's SPI mode.
    task automatic xfer(input int m, input logic [7:0] mo, input int nb,
                        output logic [7:0] mi);
        logic cp;
        cp = (m == 1);
        mi = 8'd0;
        for (int i = 7; i >= 8 - nb; i--) begin
            if (!cp) begin
                mosi[m] = mo[i];
                repeat (HALF) @(negedge clk);
                sck[m] = 1'b1;
                mi[i] = miso[m];
                repeat (HALF) @(negedge clk);
                sck[m] = 1'b0;
            end else begin
                sck[m] = 1'b0;
                mosi[m] = mo[i];
                repeat (HALF) @(negedge clk);
                sck[m] = 1'b1;
                mi[i] = miso[m];
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic run_frame(input int m, input int nb, input string tag);
        logic [7:0] mo, mi, ex;
        int c, f;
        c = rxv_cnt[m];
        f = fe_cnt[m];
        ss_low(m);
        chk({tag, "_busy"}, busy[m], 1'b1);
        chk({tag, "_oe"}, oe[m], 1'b1);
        for (int k = 0; k < nb; k++) begin
            ex = mload(m);
            mo = 8'($urandom);
            xfer(m, mo, 8, mi);
            chk({tag, "_miso"}, mi, ex);
            repeat (4) @(negedge clk);
            chk({tag, "_rx"}, rx_last[m], mo);
        end
        if (m == 0) void'(mload(0));
        ss_high(m);
        chk({tag, "_rxcnt"}, 32'(rxv_cnt[m] - c), 32'(nb));
        chk({tag, "_fe"}, 32'(fe_cnt[m] - f), 32'd1);
        chk({tag, "_uf"}, uf[m], ufm[m]);
        chk({tag, "_ready"}, txr[m], qsize(m) == 0);
        chk({tag, "_idle"}, busy[m], 1'b0);
    endtask

    initial begin
        logic [7:0] mi, e0, e1, b1, b2, mo;
        int c, f;
        rst  = 2'b11;
        sck  = 2'b10;
        ss_n = 2'b11;
        mosi = 2'b00;
        txv  = 2'b00;
        txd  = '0;
        repeat (4) @(negedge clk);
        rst = 2'b00;
        repeat (6) @(negedge clk);

        for (int m = 0; m < 2; m++) begin
            chk("rst_miso", miso[m], 1'b1);
            chk("rst_oe", oe[m], 1'b0);
            chk("rst_ready", txr[m], 1'b1);
            chk("rst_rxd", rxd[m], 8'd0);
            chk("rst_rxv", rxv[m], 1'b0);
            chk("rst_fe", fe[m], 1'b0);
            chk("rst_uf", uf[m], 1'b0);
            chk("rst_busy", busy[m], 1'b0);
        end

        // Mode 0 single byte with a preloaded reply.
        push(0, 8'hA5);
        mpush(0, 8'hA5);
        chk("m0_ready_full", txr[0], 1'b0);
        c = rxv_cnt[0];
        f = fe_cnt[0];
        ss_low(0);
        e0 = mload(0);
        chk("m0_busy", busy[0], 1'b1);
        chk("m0_ready_free", txr[0], qsize(0) == 0);
        xfer(0, 8'h3C, 8, mi);
        chk("m0_miso", mi, e0);
        void'(mload(0));
        ss_high(0);
        chk("m0_rx", rx_last[0], 8'h3C);
        chk("m0_rxcnt", 32'(rxv_cnt[0] - c), 32'd1);
        chk("m0_fe", 32'(fe_cnt[0] - f), 32'd1);
        chk("m0_oe_off", oe[0], 1'b0);

        // Mode 3 two-byte frame with a handshake between bytes.
        c = rxv_cnt[1];
        f = fe_cnt[1];
        push(1, 8'h12);
        mpush(1, 8'h12);
        ss_low(1);
        e0 = mload(1);
        xfer(1, 8'hC3, 8, mi);
        chk("m3_miso0", mi, e0);
        repeat (4) @(negedge clk);
        chk("m3_rx0", rx_last[1], 8'hC3);
        push(1, 8'h34);
        mpush(1, 8'h34);
        e1 = mload(1);
        xfer(1, 8'h5A, 8, mi);
        chk("m3_miso1", mi, e1);
        ss_high(1);
        chk("m3_rx1", rx_last[1], 8'h5A);
        chk("m3_rxcnt", 32'(rxv_cnt[1] - c), 32'd2);
        chk("m3_fe", 32'(fe_cnt[1] - f), 32'd1);
        chk("m3_uf", uf[1], 1'b0);

        // Underrun: nothing queued, idle fill goes out and the flag sticks.
        ss_low(0);
        e0 = mload(0);
        xfer(0, 8'h81, 8, mi);
        void'(mload(0));
        ss_high(0);
        chk("ur_miso", mi, e0);
        chk("ur_flag", uf[0], ufm[0]);
        push(0, 8'h6E);
        mpush(0, 8'h6E);
        chk("ur_clear", uf[0], ufm[0]);
        run_frame(0, 1, "ur_next");

        // Partial frame is discarded; the next frame starts clean.
        c = rxv_cnt[0];
        f = fe_cnt[0];
        ss_low(0);
        void'(mload(0));
        xfer(0, 8'hF0, 5, mi);
        ss_high(0);
        chk("part_rxcnt", 32'(rxv_cnt[0] - c), 32'd0);
        chk("part_fe", 32'(fe_cnt[0] - f), 32'd1);
        b1 = 8'($urandom);
        push(0, b1);
        mpush(0, b1);
        run_frame(0, 1, "part_next");

        // Reset mid-byte with SS held low.
        ss_low(0);
        void'(mload(0));
        mo = 8'($urandom);
        xfer(0, mo, 3, mi);
        c = rxv_cnt[0];
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        q0.delete();
        ufm[0] = 1'b0;
        chk("mrst_miso", miso[0], 1'b1);
        chk("mrst_oe", oe[0], 1'b0);
        chk("mrst_ready", txr[0], 1'b1);
        chk("mrst_rxd", rxd[0], 8'd0);
        chk("mrst_uf", uf[0], 1'b0);
        chk("mrst_busy", busy[0], 1'b0);
        xfer(0, 8'hFF, 5, mi);
        chk("mrst_still_idle", busy[0], 1'b0);
        chk("mrst_rxcnt", 32'(rxv_cnt[0] - c), 32'd0);
        chk("mrst_rxd_hold", rxd[0], 8'd0);
        ss_high(0);
        b1 = 8'($urandom);
        push(0, b1);
        mpush(0, b1);
        run_frame(0, 1, "mrst_next");

        // Valid held while the holding register is consumed at SS entry.
        b1 = 8'($urandom);
        b2 = 8'($urandom);
        push(0, b1);
        mpush(0, b1);
        fork
            push(0, b2);
            ss_low(0);
        join
        e0 = mload(0);
        mpush(0, b2);
        e1 = mload(0);
        xfer(0, 8'h11, 8, mi);
        chk("bb_miso0", mi, e0);
        xfer(0, 8'h22, 8, mi);
        chk("bb_miso1", mi, e1);
        void'(mload(0));
        ss_high(0);
        chk("bb_rx1", rx_last[0], 8'h22);

        // Randomized frames in both modes.
        for (int it = 0; it < 4; it++) begin
            int m;
            m = it % 2;
            if ($urandom_range(1) == 1) begin
                b1 = 8'($urandom);
                push(m, b1);
                mpush(m, b1);
            end
            run_frame(m, 1 + $urandom_range(1), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
